// File: rtl/periph_io_responder.sv
// Purpose: peripheral endpoint of the core I/O port; buffers core writes for a host and serves core reads from host data.
// Latency: response valid RESP_LATENCY cycles after the request-sample edge; FIFO heads are first-word fall-through.
// Backpressure: full/empty FIFOs answer ERROR; requests arriving while a response is pending are dropped and flag overrun.

// Synchronous FIFO with occupancy count; push/pop are qualified internally against pre-edge full/empty.
module periph_io_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [WIDTH-1:0]           head_dat_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign push_ok    = push_i && !full_o;
   assign pop_ok     = pop_i && !empty_o;
   // Empty FIFO presents zero so the head never shows stale storage.
   assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o    = count_q;

   // Occupancy next-state: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// Top level: command decode, FIFOs and the response timing FSM. DATA_WIDTH must be at least 32 for the status word.
module periph_io_responder #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned RESP_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            to_peripheral,
   input  logic [DATA_WIDTH-1:0] to_peripheral_data,
   input  logic                  to_peripheral_valid,
   output logic [1:0]            from_peripheral,
   output logic [DATA_WIDTH-1:0] from_peripheral_data,
   output logic                  from_peripheral_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] CMD_NOP    = 2'b00;
   localparam logic [1:0] CMD_WRITE  = 2'b01;
   localparam logic [1:0] CMD_READ   = 2'b10;
   localparam logic [1:0] CMD_STATUS = 2'b11;

   localparam logic [1:0] RSP_NONE  = 2'b00;
   localparam logic [1:0] RSP_ACK   = 2'b01;
   localparam logic [1:0] RSP_DATA  = 2'b10;
   localparam logic [1:0] RSP_ERROR = 2'b11;

   // Counter load: zero means the response goes out on the sample edge itself.
   localparam logic [3:0] LAT_LOAD = 4'(RESP_LATENCY - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [1:0]            pend_code_q;
   logic [DATA_WIDTH-1:0] pend_dat_q;
   logic                  fp_vld_q;
   logic [1:0]            fp_code_q;
   logic [DATA_WIDTH-1:0] fp_dat_q;
   logic                  overrun_q;

   logic [1:0]            rsp_code_d;
   logic [DATA_WIDTH-1:0] rsp_dat_d;
   logic [DATA_WIDTH-1:0] status_w;

   logic                  cmd_req;
   logic                  cmd_exec;
   logic                  wr_push;
   logic                  rd_pop;

   logic                  in_full;
   logic                  in_empty;
   logic [DATA_WIDTH-1:0] in_head;
   logic [CW-1:0]         in_cnt;
   logic                  out_full;
   logic                  out_empty;
   logic [CW-1:0]         out_cnt;

   // A non-NOP valid command is a request; it only executes when no response is pending.
   assign cmd_req  = to_peripheral_valid && (to_peripheral != CMD_NOP);
   assign cmd_exec = cmd_req && (state_q == IDLE);
   assign wr_push  = cmd_exec && (to_peripheral == CMD_WRITE) && !out_full;
   assign rd_pop   = cmd_exec && (to_peripheral == CMD_READ) && !in_empty;

   periph_io_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_in_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_i     (in_valid),
      .push_dat_i (in_data),
      .pop_i      (rd_pop),
      .full_o     (in_full),
      .empty_o    (in_empty),
      .head_dat_o (in_head),
      .count_o    (in_cnt)
   );

   periph_io_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_i     (wr_push),
      .push_dat_i (to_peripheral_data),
      .pop_i      (out_ready),
      .full_o     (out_full),
      .empty_o    (out_empty),
      .head_dat_o (out_data),
      .count_o    (out_cnt)
   );

   assign in_ready  = !in_full;
   assign out_valid = !out_empty;

   assign from_peripheral       = fp_code_q;
   assign from_peripheral_data  = fp_dat_q;
   assign from_peripheral_valid = fp_vld_q;

   // Status word: overrun in bit 31, output count in [23:16], input count in [7:0].
   always_comb begin
      status_w        = '0;
      status_w[31]    = overrun_q;
      status_w[23:16] = 8'(out_cnt);
      status_w[7:0]   = 8'(in_cnt);
   end

   // Response the current command would produce, from pre-edge FIFO state.
   always_comb begin
      rsp_code_d = RSP_NONE;
      rsp_dat_d  = '0;
      case (to_peripheral)
         CMD_WRITE: begin
            rsp_code_d = out_full ? RSP_ERROR : RSP_ACK;
         end
         CMD_READ: begin
            if (!in_empty) begin
               rsp_code_d = RSP_DATA;
               rsp_dat_d  = in_head;
            end else begin
               rsp_code_d = RSP_ERROR;
            end
         end
         CMD_STATUS: begin
            rsp_code_d = RSP_DATA;
            rsp_dat_d  = status_w;
         end
         default: begin
            rsp_code_d = RSP_NONE;
         end
      endcase
   end

   // Response FSM: latch on accept, count down, pulse valid for one cycle, drop and flag requests while busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_code_q <= RSP_NONE;
         pend_dat_q  <= '0;
         fp_vld_q    <= 1'b0;
         fp_code_q   <= RSP_NONE;
         fp_dat_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_exec) begin
                  state_q     <= BUSY;
                  cnt_q       <= LAT_LOAD;
                  pend_code_q <= rsp_code_d;
                  pend_dat_q  <= rsp_dat_d;
                  if (LAT_LOAD == 4'd0) begin
                     fp_vld_q  <= 1'b1;
                     fp_code_q <= rsp_code_d;
                     fp_dat_q  <= rsp_dat_d;
                  end
                  if (to_peripheral == CMD_STATUS) begin
                     overrun_q <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (cmd_req) begin
                  overrun_q <= 1'b1;
               end
               if (fp_vld_q) begin
                  fp_vld_q  <= 1'b0;
                  fp_code_q <= RSP_NONE;
                  fp_dat_q  <= '0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     fp_vld_q  <= 1'b1;
                     fp_code_q <= pend_code_q;
                     fp_dat_q  <= pend_dat_q;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_periph_io_responder.sv
// Bench for periph_io_responder: instance A uses RESP_LATENCY=1, instance B uses RESP_LATENCY=3.
// Expected responses are queued when a command is driven and checked by a monitor on the falling edge.
// Host-side FIFO behaviour and reset are checked directly in hand-written sequences.
module tb_periph_io_responder;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   localparam logic [1:0] C_NOP    = 2'b00;
   localparam logic [1:0] C_WRITE  = 2'b01;
   localparam logic [1:0] C_READ   = 2'b10;
   localparam logic [1:0] C_STATUS = 2'b11;

   localparam logic [1:0] R_ACK   = 2'b01;
   localparam logic [1:0] R_DATA  = 2'b10;
   localparam logic [1:0] R_ERROR = 2'b11;

   logic        clk;
   logic        rst   [2];
   logic [1:0]  cmd   [2];
   logic [31:0] cdat  [2];
   logic        cvld  [2];
   logic [1:0]  fcode [2];
   logic [31:0] fdat  [2];
   logic        fvld  [2];
   logic [31:0] idat  [2];
   logic        ivld  [2];
   logic        irdy  [2];
   logic [31:0] odat  [2];
   logic        ovld  [2];
   logic        ordy  [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulses [2];

   typedef struct {
      int          inst;
      logic [1:0]  code;
      logic [31:0] dat;
      int          due;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] dat;
      logic        hpush;
      logic [31:0] hdat;
      logic        hpop;
      logic [1:0]  ecode;
      logic [31:0] edat;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   periph_io_responder #(
      .DATA_WIDTH   (32),
      .FIFO_DEPTH   (8),
      .RESP_LATENCY (LAT_A)
   ) dut_a (
      .clock                 (clk),
      .reset                 (rst[0]),
      .to_peripheral         (cmd[0]),
      .to_peripheral_data    (cdat[0]),
      .to_peripheral_valid   (cvld[0]),
      .from_peripheral       (fcode[0]),
      .from_peripheral_data  (fdat[0]),
      .from_peripheral_valid (fvld[0]),
      .in_data               (idat[0]),
      .in_valid              (ivld[0]),
      .in_ready              (irdy[0]),
      .out_data              (odat[0]),
      .out_valid             (ovld[0]),
      .out_ready             (ordy[0])
   );

   periph_io_responder #(
      .DATA_WIDTH   (32),
      .FIFO_DEPTH   (8),
      .RESP_LATENCY (LAT_B)
   ) dut_b (
      .clock                 (clk),
      .reset                 (rst[1]),
      .to_peripheral         (cmd[1]),
      .to_peripheral_data    (cdat[1]),
      .to_peripheral_valid   (cvld[1]),
      .from_peripheral       (fcode[1]),
      .from_peripheral_data  (fdat[1]),
      .from_peripheral_valid (fvld[1]),
      .in_data               (idat[1]),
      .in_valid              (ivld[1]),
      .in_ready              (irdy[1]),
      .out_data              (odat[1]),
      .out_valid             (ovld[1]),
      .out_ready             (ordy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst %0d got %h expected %h", nm, inst, act, exp);
      end
   endfunction

   function automatic vec_t mk(logic [1:0] c, logic [31:0] d, logic hp, logic [31:0] hd,
                               logic po, logic [1:0] ec, logic [31:0] ed);
      vec_t v;
      v.cmd   = c;
      v.dat   = d;
      v.hpush = hp;
      v.hdat  = hd;
      v.hpop  = po;
      v.ecode = ec;
      v.edat  = ed;
      return v;
   endfunction

   // Response monitor: every pulse must match the queue head, including its cycle; idle outputs must be zero.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (fvld[i] === 1'b1) begin
            exp_t e;
            pulses[i]++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp inst %0d code %0d data %h", i, fcode[i], fdat[i]);
            end else begin
               e = sbq.pop_front();
               chk("rsp_inst", i, i, e.inst);
               chk("rsp_code", i, {30'd0, fcode[i]}, {30'd0, e.code});
               chk("rsp_data", i, fdat[i], e.dat);
               chk("rsp_cycle", i, cyc, e.due);
            end
         end else begin
            chk("idle_code", i, {30'd0, fcode[i]}, 32'd0);
            chk("idle_data", i, fdat[i], 32'd0);
         end
      end
   end

   task automatic issue(input int i, input logic [1:0] c, input logic [31:0] d,
                        input bit expect_rsp, input logic [1:0] ec, input logic [31:0] ed);
      exp_t e;
      cmd[i]  = c;
      cdat[i] = d;
      cvld[i] = 1'b1;
      if (expect_rsp) begin
         e.inst = i;
         e.code = ec;
         e.dat  = ed;
         e.due  = cyc + ((i == 0) ? LAT_A : LAT_B);
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      cvld[i] = 1'b0;
      cmd[i]  = C_NOP;
      cdat[i] = '0;
   endtask

   task automatic wait_resp();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (sbq.size() != 0 && n < 40);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout pending %0d", sbq.size());
         sbq.delete();
      end
      #1;
   endtask

   task automatic host_push(input int i, input logic [31:0] d);
      ivld[i] = 1'b1;
      idat[i] = d;
      @(posedge clk);
      #1;
      ivld[i] = 1'b0;
      idat[i] = '0;
   endtask

   task automatic pop_chk(input int i, input logic [31:0] exp);
      chk("out_valid", i, {31'd0, ovld[i]}, 32'd1);
      chk("out_data", i, odat[i], exp);
      ordy[i] = 1'b1;
      @(posedge clk);
      #1;
      ordy[i] = 1'b0;
   endtask

   task automatic reset_state_chk(input int i);
      chk("rst_fvld", i, {31'd0, fvld[i]}, 32'd0);
      chk("rst_fcode", i, {30'd0, fcode[i]}, 32'd0);
      chk("rst_fdata", i, fdat[i], 32'd0);
      chk("rst_in_ready", i, {31'd0, irdy[i]}, 32'd1);
      chk("rst_out_valid", i, {31'd0, ovld[i]}, 32'd0);
      chk("rst_out_data", i, odat[i], 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench stopped by watchdog");
   end

   initial begin
      logic [31:0] drain_exp [7];
      int snap;

      for (int i = 0; i < 2; i++) begin
         rst[i]    = 1'b1;
         cmd[i]    = C_NOP;
         cdat[i]   = '0;
         cvld[i]   = 1'b0;
         idat[i]   = '0;
         ivld[i]   = 1'b0;
         ordy[i]   = 1'b0;
         pulses[i] = 0;
      end

      // Table for instance A: host push/pop columns share the cycle with the command.
      vecs[0]  = mk(C_NOP,    32'h0,  1'b1, 32'h11, 1'b0, 2'b00,   32'h0);
      vecs[1]  = mk(C_NOP,    32'h0,  1'b1, 32'h22, 1'b0, 2'b00,   32'h0);
      vecs[2]  = mk(C_READ,   32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h11);
      vecs[3]  = mk(C_READ,   32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h22);
      vecs[4]  = mk(C_READ,   32'h0,  1'b0, 32'h0,  1'b0, R_ERROR, 32'h0);
      vecs[5]  = mk(C_READ,   32'h0,  1'b1, 32'h55, 1'b0, R_ERROR, 32'h0);
      vecs[6]  = mk(C_READ,   32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h55);
      vecs[7]  = mk(C_STATUS, 32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h0);
      for (int k = 0; k < 8; k++) begin
         vecs[8+k] = mk(C_WRITE, 32'(k + 1), 1'b0, 32'h0, 1'b0, R_ACK, 32'h0);
      end
      vecs[16] = mk(C_WRITE,  32'h9,  1'b0, 32'h0,  1'b0, R_ERROR, 32'h0);
      vecs[17] = mk(C_STATUS, 32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h0008_0000);
      vecs[18] = mk(C_WRITE,  32'hA,  1'b0, 32'h0,  1'b1, R_ERROR, 32'h0);
      vecs[19] = mk(C_STATUS, 32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h0007_0000);
      vecs[20] = mk(C_WRITE,  32'hB,  1'b0, 32'h0,  1'b1, R_ACK,   32'h0);
      vecs[21] = mk(C_NOP,    32'h0,  1'b1, 32'h66, 1'b0, 2'b00,   32'h0);
      vecs[22] = mk(C_READ,   32'h0,  1'b1, 32'h77, 1'b0, R_DATA,  32'h66);
      vecs[23] = mk(C_STATUS, 32'h0,  1'b0, 32'h0,  1'b0, R_DATA,  32'h0007_0001);

      drain_exp = '{32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hB};

      #2;
      reset_state_chk(0);
      reset_state_chk(1);
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk);
      #1;
      reset_state_chk(0);

      // A: write handshake and host drain.
      issue(0, C_WRITE, 32'hDEAD_BEEF, 1'b1, R_ACK, 32'h0);
      wait_resp();
      pop_chk(0, 32'hDEAD_BEEF);
      chk("out_valid_after_pop", 0, {31'd0, ovld[0]}, 32'd0);

      // A: table-driven read, status, full and simultaneous-event cases.
      for (int k = 0; k < NV; k++) begin
         exp_t e;
         cmd[0]  = vecs[k].cmd;
         cdat[0] = vecs[k].dat;
         cvld[0] = (vecs[k].cmd != C_NOP);
         ivld[0] = vecs[k].hpush;
         idat[0] = vecs[k].hdat;
         ordy[0] = vecs[k].hpop;
         if (vecs[k].cmd != C_NOP) begin
            e.inst = 0;
            e.code = vecs[k].ecode;
            e.dat  = vecs[k].edat;
            e.due  = cyc + LAT_A;
            sbq.push_back(e);
         end
         @(posedge clk);
         #1;
         cmd[0]  = C_NOP;
         cdat[0] = '0;
         cvld[0] = 1'b0;
         ivld[0] = 1'b0;
         idat[0] = '0;
         ordy[0] = 1'b0;
         if (vecs[k].cmd != C_NOP) begin
            wait_resp();
         end
      end

      // A: output FIFO keeps order; rejected words never appear.
      for (int k = 0; k < 7; k++) begin
         pop_chk(0, drain_exp[k]);
      end
      chk("out_valid_drained", 0, {31'd0, ovld[0]}, 32'd0);
      issue(0, C_READ, 32'h0, 1'b1, R_DATA, 32'h77);
      wait_resp();
      issue(0, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h0);
      wait_resp();

      // B: request one cycle into a pending response is dropped and sets overrun.
      issue(1, C_WRITE, 32'hAAAA_0001, 1'b1, R_ACK, 32'h0);
      issue(1, C_READ, 32'h0, 1'b0, 2'b00, 32'h0);
      wait_resp();
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h8001_0000);
      wait_resp();
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h0001_0000);
      wait_resp();

      // B: a dropped STATUS sets overrun rather than clearing it.
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h0001_0000);
      issue(1, C_STATUS, 32'h0, 1'b0, 2'b00, 32'h0);
      wait_resp();
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h8001_0000);
      wait_resp();

      // B: request sampled on the edge that ends the valid cycle is still dropped.
      issue(1, C_WRITE, 32'hAAAA_0002, 1'b1, R_ACK, 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      issue(1, C_READ, 32'h0, 1'b0, 2'b00, 32'h0);
      wait_resp();
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h8002_0000);
      wait_resp();

      // B: reset while a response is pending discards it and empties both FIFOs.
      host_push(1, 32'h99);
      host_push(1, 32'h9A);
      issue(1, C_READ, 32'h0, 1'b0, 2'b00, 32'h0);
      rst[1] = 1'b1;
      #1;
      reset_state_chk(1);
      snap = pulses[1];
      repeat (3) @(posedge clk);
      #1;
      rst[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("no_rsp_after_reset", 1, pulses[1], snap);
      chk("post_rst_in_ready", 1, {31'd0, irdy[1]}, 32'd1);
      chk("post_rst_out_valid", 1, {31'd0, ovld[1]}, 32'd0);
      issue(1, C_STATUS, 32'h0, 1'b1, R_DATA, 32'h0);
      wait_resp();

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_io_responder.md
Name: periph_io_responder

Overview:
- Peripheral-side endpoint of the core's I/O port. It consumes the core's to_peripheral command, data and valid outputs, and drives the core's from_peripheral response, data and valid inputs.
- It buffers core writes in an output FIFO that an external host drains.
- It serves core reads from an input FIFO that the external host fills.
- It reports FIFO occupancy and a sticky overrun flag on a status command.

Parameters:
- DATA_WIDTH, 32: width of command and response data words.
- FIFO_DEPTH, 8: entries per FIFO. Power of two, 2..128.
- RESP_LATENCY, 1: cycles from the request-sample edge to the response-valid cycle. Range 1..15.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- to_peripheral  input  2  command from core: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
- to_peripheral_data  input  DATA_WIDTH  write payload from core.
- to_peripheral_valid  input  1  command valid, single-cycle pulse.
- from_peripheral  output  2  response code: 00 none, 01 ACK, 10 DATA, 11 ERROR.
- from_peripheral_data  output  DATA_WIDTH  response payload.
- from_peripheral_valid  output  1  response valid, single-cycle pulse.
- in_data  input  DATA_WIDTH  host word destined for core reads.
- in_valid  input  1  host push request.
- in_ready  output  1  input FIFO not full.
- out_data  output  DATA_WIDTH  head of output FIFO (first-word fall-through).
- out_valid  output  1  output FIFO not empty.
- out_ready  input  1  host pop acknowledge.

Behaviour:
- Reset, asynchronous:
  - Both FIFOs emptied; overrun cleared.
  - FSM to IDLE; any pending response discarded.
  - Outputs: from_peripheral=00, from_peripheral_data=0, from_peripheral_valid=0, in_ready=1, out_valid=0, out_data=0.
- FSM states: IDLE, BUSY.
- IDLE → BUSY on a rising edge with to_peripheral_valid=1 and to_peripheral≠00. At that edge the command executes and its response is latched; a down-counter loads RESP_LATENCY−1.
- NOP with valid=1 is ignored: no state change, no response.
- Command execution, evaluated on pre-edge FIFO state:
  - WRITE: output FIFO not full → push to_peripheral_data; response ACK, data 0. Full → no push; response ERROR, data 0.
  - READ: input FIFO not empty → pop head; response DATA, data = popped word. Empty → response ERROR, data 0.
  - STATUS response is DATA with this payload:
    - bit31 = overrun.
    - bits[23:16] = output FIFO count.
    - bits[7:0] = input FIFO count.
    - all other bits 0.
    - Overrun is cleared at this edge.
- Response timing:
  - from_peripheral_valid=1 for exactly one cycle, RESP_LATENCY cycles after the sample edge. RESP_LATENCY=1 gives valid in the cycle immediately after the sample edge.
  - Code and data are stable only while valid=1; they return to 00/0 otherwise.
  - FSM → IDLE on the edge that ends the valid cycle.
- Request while BUSY, including the response-valid cycle:
  - Request is dropped, with no FIFO effect.
  - overrun is set, sticky.
  - A STATUS dropped this way does not clear overrun.
- FIFO behaviour:
  - Input FIFO push when in_valid && in_ready.
  - Output FIFO pop when out_valid && out_ready.
  - Counts range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Simultaneous events:
  - Host push and core READ in the same cycle on an empty input FIFO → READ answers ERROR; the pushed word remains (count 1).
  - Host pop and core WRITE in the same cycle on a full output FIFO → WRITE answers ERROR; count becomes DEPTH−1.
  - Host push and core READ on a non-empty, non-full FIFO → count unchanged.
  - Host pop and core WRITE on a non-empty, non-full FIFO → count unchanged.
- Ordering: FIFOs are strictly in order; the input FIFO delivers words in host push order.
- Counter width: $clog2(FIFO_DEPTH)+1, zero-extended into the status fields.

Test Plan:
- Reset and WRITE handshake:
  - Release reset, then WRITE 0xDEADBEEF, RESP_LATENCY=1.
  - Next cycle: valid=1, code 01, data 0.
  - out_valid=1, out_data=0xDEADBEEF; out_ready=1 pops it and out_valid returns to 0.
- READ path and empty case:
  - Host pushes 0x11, 0x22.
  - Two READs return DATA 0x11, then 0x22.
  - A third READ returns ERROR with data 0.
- Output FIFO full:
  - 9 WRITEs 0x1..0x9 with out_ready=0, each issued after the prior response.
  - First 8 responses ACK; 9th is ERROR.
  - Draining yields 0x1..0x8; the 9th word is not stored.
- Overrun and STATUS:
  - RESP_LATENCY=3; WRITE, then READ one cycle later.
  - Only the WRITE response appears.
  - A subsequent STATUS returns 0x80010000; a second STATUS returns 0x00010000.
- Simultaneous push and read on empty FIFO:
  - in_valid=1 with in_data 0x55 in the same cycle as READ.
  - READ returns ERROR; the next READ returns DATA 0x55.
- Reset mid-operation:
  - RESP_LATENCY=3, READ issued, then reset asserted one cycle later.
  - No response pulse appears; both FIFOs are empty and in_ready=1 immediately after assertion.
